// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
// The optional edge pulses are enabled by defining SW_DEBOUNCE_EDGE_EN.
package sw_debounce_pkg;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } db_state_e;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/sw_debounce_bit.sv
// One-bit debouncer: synchronizer, STABLE/PENDING state, stability counter, edge pulses.
// sw rise/fall pulses exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter logic        RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_bit;
   db_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
      sync_bit = sync_q[SYNC_STAGES-1];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      unique case (state_q)
         STABLE: begin
            if (sync_bit != level_q) begin
               state_d = PENDING;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         PENDING: begin
            // A level matching the accepted one mid-count is a glitch: drop it.
            if (sync_bit == level_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = STABLE;
               cnt_d   = '0;
               level_d = ~level_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= {SYNC_STAGES{RESET_VAL}};
         state_q <= STABLE;
         cnt_q   <= '0;
         level_q <= RESET_VAL;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;

`ifdef SW_DEBOUNCE_EDGE_EN
   logic rise_q, rise_d, fall_q, fall_d;

   // Pulses register alongside level_q so they coincide with the new output level.
   always_comb begin
      rise_d = ~level_q & level_d;
      fall_d = level_q & ~level_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer: WIDTH independent sw_debounce_bit instances.
// Edge pulses are compiled in only with SW_DEBOUNCE_EDGE_EN defined.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int unsigned       WIDTH           = 3,
   parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned       SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter logic [WIDTH-1:0]  RESET_VAL       = '0
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_external_connection_export,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES),
         .RESET_VAL       (RESET_VAL[i])
      ) u_bit (
         .clk   (clk_clk),
         .rst   (reset_reset),
         .raw   (sw_raw[i]),
         .level (sw_external_connection_export[i]),
         .rise  (sw_rise[i]),
         .fall  (sw_fall[i])
      );
   end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random toggling against a
// reference that accepts a level once DEBOUNCE_CYCLES consecutive synchronized samples differ.
module tb_sw_debounce;

   localparam int W  = 3;
   localparam int DC = 4;
   localparam int SS = 2;
   localparam int H  = 2048;
   localparam logic [W-1:0] RV = '0;
`ifdef SW_DEBOUNCE_EDGE_EN
   localparam logic [W-1:0] EDGE_MASK = '1;
`else
   localparam logic [W-1:0] EDGE_MASK = '0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] raw = 3'b111;
   logic [W-1:0] q, rise, fall;

   always #5 clk = ~clk;

   sw_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DC),
      .SYNC_STAGES     (SS),
      .RESET_VAL       (RV)
   ) dut (
      .clk_clk                       (clk),
      .reset_reset                   (rst),
      .sw_raw                        (raw),
      .sw_external_connection_export (q),
      .sw_rise                       (rise),
      .sw_fall                       (fall)
   );

   int n_pass  = 0;
   int n_total = 0;
   int n       = 0;

   logic [W-1:0] raw_h [H];
   logic [W-1:0] s_h   [H];
   logic [W-1:0] lvl_h [H];
   logic [W-1:0] rise_h[H];
   logic [W-1:0] fall_h[H];
   bit           rst_h [H];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One rising edge: record inputs, evaluate the reference, compare outputs 1 ns later.
   task automatic tick();
      @(posedge clk);
      if (n >= H) begin
         $display("FAIL history_overflow observed=%0d expected<%0d", n, H);
         $fatal(1, "history overflow");
      end
      raw_h[n] = raw;
      rst_h[n] = rst;
      for (int b = 0; b < W; b++) begin
         logic sv, prev, lv;
         bit   flip;
         if (n - SS + 1 < 0) sv = RV[b];
         else begin
            sv = raw_h[n-SS+1][b];
            for (int k = n - SS + 1; k <= n; k++) if (rst_h[k]) sv = RV[b];
         end
         s_h[n][b] = sv;
         prev = (n == 0) ? RV[b] : lvl_h[n-1][b];
         flip = !rst && (n >= DC);
         if (flip) for (int k = 1; k <= DC; k++) if (s_h[n-k][b] == prev) flip = 1'b0;
         lv = rst ? RV[b] : (flip ? ~prev : prev);
         lvl_h[n][b]  = lv;
         rise_h[n][b] = EDGE_MASK[b] & !rst & !prev & lv;
         fall_h[n][b] = EDGE_MASK[b] & !rst & prev & !lv;
      end
      #1;
      chk("level", 32'(q), 32'(lvl_h[n]));
      chk("rise", 32'(rise), 32'(rise_h[n]));
      chk("fall", 32'(fall), 32'(fall_h[n]));
      chk("rise_fall_exclusive", 32'(rise & fall), 32'd0);
      n++;
   endtask

   initial begin
      // Scenario 1: reset with all switches high, then release.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s1_reset_out", 32'(q), 32'd0);
         chk("s1_reset_rise", 32'(rise), 32'd0);
      end
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("s1_wait_out", 32'(q), 32'd0);
      end
      tick();
      chk("s1_out", 32'(q), 32'h7);
      chk("s1_rise", 32'(rise), 32'(EDGE_MASK));
      tick();
      chk("s1_rise_end", 32'(rise), 32'd0);
      chk("s1_hold", 32'(q), 32'h7);

      // Scenario 2: bit 0 rises from a settled all-zero level.
      raw = 3'b000;
      for (int i = 0; i < 10; i++) tick();
      chk("s2_pre", 32'(q), 32'd0);
      raw = 3'b001;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("s2_wait", 32'(q[0]), 32'd0);
      end
      tick();
      chk("s2_out", 32'(q[0]), 32'd1);
      chk("s2_rise", 32'(rise[0]), 32'(EDGE_MASK[0]));
      tick();
      chk("s2_rise_end", 32'(rise[0]), 32'd0);

      // Scenario 3: 3-cycle glitch on bit 1.
      raw[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s3_out", 32'(q[1]), 32'd0);
      end
      raw[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("s3_out", 32'(q[1]), 32'd0);
         chk("s3_rise", 32'(rise[1]), 32'd0);
      end

      // Scenario 4: bit 2 toggles every 2 cycles for 40 cycles, then held high.
      for (int i = 0; i < 10; i++) begin
         raw[2] = 1'b1;
         tick(); chk("s4_toggle", 32'(q[2]), 32'd0);
         tick(); chk("s4_toggle", 32'(q[2]), 32'd0);
         raw[2] = 1'b0;
         tick(); chk("s4_toggle", 32'(q[2]), 32'd0);
         tick(); chk("s4_toggle", 32'(q[2]), 32'd0);
      end
      raw[2] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("s4_wait", 32'(q[2]), 32'd0);
      end
      tick();
      chk("s4_out", 32'(q[2]), 32'd1);
      chk("s4_rise", 32'(rise[2]), 32'(EDGE_MASK[2]));

      // Scenario 5: reset during a pending change on bit 0.
      raw = 3'b000;
      for (int i = 0; i < 10; i++) tick();
      chk("s5_pre", 32'(q), 32'd0);
      raw = 3'b001;
      for (int i = 0; i < 5; i++) tick();
      chk("s5_pending_cnt", 32'(dut.g_bit[0].u_bit.cnt_q), 32'd3);
      rst = 1'b1;
      tick();
      chk("s5_out", 32'(q), 32'd0);
      chk("s5_cnt", 32'(dut.g_bit[0].u_bit.cnt_q), 32'd0);
      chk("s5_rise", 32'(rise), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      raw = 3'b000;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("s5_after", 32'(q), 32'd0);
         chk("s5_after_rise", 32'(rise), 32'd0);
      end

      // Random toggling with occasional resets, checked only against the reference.
      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(99) == 0);
         for (int b = 0; b < W; b++)
            if ($urandom_range(7) == 0) raw[b] = ~raw[b];
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 3: number of independent switch bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles needed to accept a new level; legal range >= 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth; legal range >= 2.
REQ-004 SHALL have parameter RESET_VAL, WIDTH bits, default all-zero: accepted level loaded at reset.
REQ-005 SHALL have port clk_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset_reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port sw_raw, input, WIDTH bits: asynchronous, bouncing switch pins.
REQ-008 SHALL have port sw_external_connection_export, output, WIDTH bits: debounced level that feeds the system switch PIO.
REQ-009 SHALL have port sw_rise, output, WIDTH bits: one-cycle pulse per bit when the accepted level goes 0->1.
REQ-010 SHALL have port sw_fall, output, WIDTH bits: one-cycle pulse per bit when the accepted level goes 1->0.

Function
REQ-011 SHALL pass each sw_raw bit through a SYNC_STAGES-deep flop chain before any other logic uses it.
REQ-012 SHALL hold, per bit, a state (STABLE, PENDING), an accepted level and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-013 In STABLE, a synchronized bit equal to the accepted level SHALL keep the state STABLE with the counter at 0.
REQ-014 In STABLE, a synchronized bit that differs from the accepted level SHALL move the state to PENDING and load the counter with 1.
REQ-015 In PENDING, a synchronized bit that still differs with counter < DEBOUNCE_CYCLES-1 SHALL increment the counter.
REQ-016 In PENDING, a synchronized bit that still differs with counter == DEBOUNCE_CYCLES-1 SHALL invert the accepted level, clear the counter and return the state to STABLE in the same cycle.
REQ-017 In PENDING, a synchronized bit that equals the accepted level SHALL clear the counter and return the state to STABLE, leaving the accepted level unchanged (glitch rejection).
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 sw_external_connection_export SHALL be the registered accepted level.
REQ-020 A clean raw transition SHALL appear on the output exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw value.
REQ-021 sw_rise or sw_fall SHALL be registered and high for exactly the one cycle in which the output shows the new level.
REQ-022 sw_rise and sw_fall SHALL never be high together for the same bit.
REQ-023 Each bit SHALL be independent; simultaneous changes on several bits SHALL each be debounced with no interaction.

Reset
REQ-024 While reset_reset is high at a clock edge: synchronizer flops SHALL load RESET_VAL, accepted level SHALL load RESET_VAL, state SHALL load STABLE, counters SHALL load 0, and sw_rise and sw_fall SHALL load 0.
REQ-025 Reset asserted during PENDING SHALL abandon the pending change, and reset SHALL never generate an edge pulse.

Configuration
REQ-026 With SW_DEBOUNCE_EDGE_EN defined, the edge-detect registers and the sw_rise and sw_fall logic SHALL be compiled in.
REQ-027 With SW_DEBOUNCE_EDGE_EN undefined, the edge-detect logic SHALL be absent and sw_rise and sw_fall SHALL be tied to 0; the level path SHALL be identical to the defined case.

Structure
REQ-028 Shared package sw_debounce_pkg SHALL hold the state enum (STABLE, PENDING) and the default constants for DEBOUNCE_CYCLES and SYNC_STAGES.
REQ-029 Sub-module sw_debounce_bit SHALL implement the synchronizer, state, counter and edge logic for one bit; sw_debounce SHALL instantiate it WIDTH times in a generate loop.

Verification
REQ-030 The bench SHALL use WIDTH=3, DEBOUNCE_CYCLES=4, SYNC_STAGES=2 and RESET_VAL=0 for all scenarios.
REQ-031 Scenario 1: hold reset 3 cycles with sw_raw=3'b111 -> the output reads 3'b000, no pulses occur, and 6 edges after release the output reads 3'b111 with sw_rise=3'b111 for 1 cycle.
REQ-032 Scenario 2: sw_raw[0] 0->1 and held -> the output bit 0 rises on edge 6 with sw_rise[0] high for that one cycle.
REQ-033 Scenario 3: a 3-cycle high glitch on sw_raw[1] -> the output and the pulses stay 0 throughout.
REQ-034 Scenario 4: sw_raw[2] toggling every 2 cycles for 40 cycles, then held at 1 -> no output change during the toggling, and the output rises 6 edges after the final transition.
REQ-035 Scenario 5: reset asserted after 3 cycles of a pending change on bit 0 -> the output stays 0, the counter returns to 0 and no pulse occurs.
REQ-036 Scenario 6: with SW_DEBOUNCE_EDGE_EN undefined, repeat scenario 2 -> the level timing is identical and sw_rise and sw_fall stay 0.
